// File: rtl/hex_led_avmm.sv
// -----------------------------------------------------------------------------
// hex_led_avmm
//
// Avalon-MM slave that drives the six seven-segment displays (HEX0..HEX5) and
// the ten red LEDs. Software writes hex digits, per-digit enable and blink
// masks and an LED pattern. Digits are decoded to active-low segment patterns.
// A free-running prescaler sets the blink phase. All pin outputs are registered.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   avs_address[2:0]    word address
//   avs_write           write strobe (accepted the cycle it is presented)
//   avs_writedata[31:0] write data
//   avs_read            read strobe (accepted the cycle it is presented)
//   avs_readdata[31:0]  read data, valid while avs_readdatavalid is high
//   avs_readdatavalid   one-cycle read response pulse
//   hex0..hex5[6:0]     active-low segments, bit0 = a .. bit6 = g
//   ledr[9:0]           red LEDs, active-high
//
// Register map (word addresses; unlisted bits read 0):
//   0 DIG_LO  d0[3:0] d1[7:4] d2[11:8] d3[15:12]
//   1 DIG_HI  d4[3:0] d5[7:4]
//   2 CTRL    enable[5:0] blink[13:8]
//   3 LED     ledr[9:0]
//   4 STATUS  phase[0] toggle_count[15:8]   (read-only)
//   5..7      read 0, writes ignored
// -----------------------------------------------------------------------------
module hex_led_avmm #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BLINK_HZ    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [9:0]  ledr
);

    // Prescaler half-period in clock cycles. The counter is kept at least one
    // bit wide so that HP = 1 (toggle every cycle) still elaborates.
    localparam int             HP        = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int             PW        = (HP > 1) ? $clog2(HP) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(HP - 1);

    localparam logic [2:0] ADDR_DIG_LO = 3'd0;
    localparam logic [2:0] ADDR_DIG_HI = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_LED    = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } blink_state_e;

    // Software-visible registers
    logic [15:0] dig_lo_q, dig_lo_d;
    logic [7:0]  dig_hi_q, dig_hi_d;
    logic [5:0]  en_q, en_d;
    logic [5:0]  blink_q, blink_d;
    logic [9:0]  led_q, led_d;

    // Blink machinery
    logic [PW-1:0] presc_q, presc_d;
    blink_state_e  state_q, state_d;
    logic [7:0]    tcount_q, tcount_d;
    logic          presc_wrap;

    // Registered outputs
    logic [5:0][6:0] hex_q, hex_d;
    logic [9:0]      ledr_q, ledr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;

    logic [31:0] rd_mux;
    logic [23:0] digits;

    // Upper write-data bits have no destination in any register.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:16];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // -------------------------------------------------------------------------
    // Blink FSM: free-running, only moves on prescaler wrap. CTRL writes do
    // not touch it, so software changes never disturb the blink cadence.
    // -------------------------------------------------------------------------
    assign presc_wrap = (presc_q == PRESC_MAX);

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no
        // path leaves it unassigned and a latch is never inferred.
        presc_d  = presc_q + PW'(1);
        state_d  = state_q;
        tcount_d = tcount_q;
        if (presc_wrap) begin
            presc_d  = '0;
            tcount_d = tcount_q + 8'd1;
            case (state_q)
                SHOW:    state_d = BLANK;
                default: state_d = SHOW;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Register writes and read mux. The mux looks at current register state,
    // so a read paired with a write in the same cycle returns the old value.
    // -------------------------------------------------------------------------
    always_comb begin
        dig_lo_d = dig_lo_q;
        dig_hi_d = dig_hi_q;
        en_d     = en_q;
        blink_d  = blink_q;
        led_d    = led_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_DIG_LO: dig_lo_d = avs_writedata[15:0];
                ADDR_DIG_HI: dig_hi_d = avs_writedata[7:0];
                ADDR_CTRL: begin
                    en_d    = avs_writedata[5:0];
                    blink_d = avs_writedata[13:8];
                end
                ADDR_LED:    led_d = avs_writedata[9:0];
                default: ;
            endcase
        end

        rd_mux = '0;
        case (avs_address)
            ADDR_DIG_LO: rd_mux = {16'h0, dig_lo_q};
            ADDR_DIG_HI: rd_mux = {24'h0, dig_hi_q};
            ADDR_CTRL:   rd_mux = {18'h0, blink_q, 2'b00, en_q};
            ADDR_LED:    rd_mux = {22'h0, led_q};
            ADDR_STATUS: rd_mux = {16'h0, tcount_q, 7'h0, (state_q == BLANK)};
            default:     rd_mux = '0;
        endcase

        // Read data is held between responses; only the valid flag pulses.
        rvalid_d = avs_read;
        rdata_d  = avs_read ? rd_mux : rdata_q;
    end

    // -------------------------------------------------------------------------
    // Display decode. Outputs are registered from the current register and
    // phase state, so any change shows on the pins one edge later.
    // -------------------------------------------------------------------------
    assign digits = {dig_hi_q, dig_lo_q};

    always_comb begin
        hex_d = '0;
        for (int i = 0; i < 6; i++) begin
            if (en_q[i] && !(blink_q[i] && (state_q == BLANK))) begin
                hex_d[i] = seg_decode(digits[4*i +: 4]);
            end else begin
                hex_d[i] = SEG_OFF;
            end
        end
        ledr_d = led_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_lo_q <= '0;
            dig_hi_q <= '0;
            en_q     <= '0;
            blink_q  <= '0;
            led_q    <= '0;
            presc_q  <= '0;
            state_q  <= SHOW;
            tcount_q <= '0;
            hex_q    <= {6{SEG_OFF}};
            ledr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            dig_lo_q <= dig_lo_d;
            dig_hi_q <= dig_hi_d;
            en_q     <= en_d;
            blink_q  <= blink_d;
            led_q    <= led_d;
            presc_q  <= presc_d;
            state_q  <= state_d;
            tcount_q <= tcount_d;
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign hex0              = hex_q[0];
    assign hex1              = hex_q[1];
    assign hex2              = hex_q[2];
    assign hex3              = hex_q[3];
    assign hex4              = hex_q[4];
    assign hex5              = hex_q[5];
    assign ledr              = ledr_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule
